// File: rtl/serial_rx.sv
// UART-style serial receiver: 2-flop synchronizer, mid-bit sampling, 8N1 frames.
// Define SERIAL_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module serial_rx #(
    parameter int SYSTEM_CLOCK = 100000000,
    parameter int BAUD_RATE    = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_dv,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = SYSTEM_CLOCK / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_LIM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic             rx_m_q, rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_dv_q, rx_dv_d;
    logic             frame_err_q, frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic at_bit_end;
    assign rx_s       = rx_s_q;
    assign at_bit_end = (cnt_q == BIT_LIM);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LIM) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (at_bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (at_bit_end) begin
                    cnt_d     = '0;
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (at_bit_end) begin
                    // Leave mid stop bit so a directly following start edge is caught.
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        rx_dv_d   = 1'b1;
                        rx_data_d = shift_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_m_q      <= rx;
            rx_s_q      <= rx_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_dv     = rx_dv_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx at default parameters (868 clocks per bit).
module tb_serial_rx;

    localparam int CPB = 868;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_dv, frame_err, parity_err;

    serial_rx dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .rx_data(rx_data), .rx_dv(rx_dv),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_dv = 0, n_ferr = 0, n_perr = 0;
    int last_dv_cyc = 0;
    int start_cyc = 0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Pulse monitor: counts pulses, checks exclusivity and that rx_data moves only with rx_dv.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_dv) begin n_dv++; last_dv_cyc = cyc; end
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (rx_dv || frame_err || parity_err)
                chk("pulse_exclusive", int'(rx_dv) + int'(frame_err) + int'(parity_err), 1);
            if (rx_data !== prev_data)
                chk("data_change_with_dv", int'(rx_dv), 1);
        end
        prev_data = rx_data;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) $display("note: parity bit unused");
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         gap_bits;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int dv0, fe0, pe0;

        vecs.push_back('{8'hA5, 1'b0, 1'b1, 2, 8'hA5, 1, 0, 0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 0, 8'h00, 1, 0, 0});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1, 0, 0});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 3, 8'hFF, 0, 1, 0});
`ifdef SERIAL_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 2, 8'h07, 1, 0, 0});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 2, 8'h07, 0, 0, 1});
`endif

        repeat (3) @(negedge clk);
        chk("reset_rx_data", int'(rx_data), 8'h00);
        chk("reset_rx_dv", int'(rx_dv), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_parity_err", int'(parity_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        foreach (vecs[k]) begin
            dv0 = n_dv; fe0 = n_ferr; pe0 = n_perr;
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stop);
            chk($sformatf("vec%0d_dv_count", k), n_dv - dv0, vecs[k].exp_dv);
            chk($sformatf("vec%0d_ferr_count", k), n_ferr - fe0, vecs[k].exp_ferr);
            chk($sformatf("vec%0d_perr_count", k), n_perr - pe0, vecs[k].exp_perr);
            chk($sformatf("vec%0d_rx_data", k), int'(rx_data), int'(vecs[k].exp_data));
            if (k == 0) begin
`ifdef SERIAL_RX_PARITY_EN
                chk("a5_latency_ok", int'((last_dv_cyc - start_cyc) >= 9117 && (last_dv_cyc - start_cyc) <= 9123), 1);
`else
                chk("a5_latency_ok", int'((last_dv_cyc - start_cyc) >= 8246 && (last_dv_cyc - start_cyc) <= 8252), 1);
`endif
            end
            repeat (vecs[k].gap_bits * CPB) @(negedge clk);
        end

        // Short low glitch must be rejected.
        dv0 = n_dv; fe0 = n_ferr; pe0 = n_perr;
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_dv", n_dv - dv0, 0);
        chk("glitch_no_ferr", n_ferr - fe0, 0);

        // Reset during bit 4 of 0x55 aborts it.
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midframe_reset_rx_data", int'(rx_data), 8'h00);
        rst_n = 1'b1;
        repeat (6 * CPB) @(negedge clk);
        chk("reset_abort_no_dv", n_dv - dv0, 0);
        chk("reset_abort_no_ferr", n_ferr - fe0, 0);

        dv0 = n_dv;
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (CPB) @(negedge clk);
        chk("post_reset_dv_count", n_dv - dv0, 1);
        chk("post_reset_rx_data", int'(rx_data), 8'h81);
        chk("post_reset_no_ferr", n_ferr - fe0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter SYSTEM_CLOCK, default 100000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed received byte.
REQ-007 SHALL have port rx_dv  output  1  one-cycle pulse: rx_data holds a new byte.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL define CLKS_PER_BIT = SYSTEM_CLOCK/BAUD_RATE (integer division; 868 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (434).
REQ-012 SHALL implement states IDLE, START, DATA, STOP; reset state IDLE.
REQ-013 IDLE: on rx_s low, go to START and clear the bit-period counter.
REQ-014 START: after HALF_BIT cycles sample rx_s; if low, go to DATA; if high (glitch), go to IDLE with no output pulse.
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles; 8 bits, LSB first, shifted into an internal register; after bit 7, go to the parity state (if compiled in) or STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx_s; if high, load rx_data and pulse rx_dv for exactly one cycle; if low, pulse frame_err for one cycle and leave rx_data unchanged.
REQ-017 STOP SHALL return to IDLE in the cycle after the stop sample (mid stop bit), so a start bit directly after the stop bit is received.
REQ-018 rx_data SHALL change only in the cycle rx_dv is asserted; it holds its value otherwise.
REQ-019 rx_dv, frame_err and parity_err SHALL never be asserted in the same cycle.
REQ-020 A low rx held past the stop bit (break) SHALL produce frame_err, then restart reception from IDLE; there is no lockout.
REQ-021 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 with no wrap-around within a bit period.

Reset
REQ-022 On rst_n low, the block SHALL immediately set state=IDLE, rx_data=8'h00, rx_dv=0, frame_err=0, parity_err=0, counters=0 and both synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception resumes at the next falling edge.

Configuration
REQ-024 With macro SERIAL_RX_PARITY_EN defined, the frame SHALL be 8E1: a PARITY state after DATA samples one even-parity bit; on mismatch the stop sample SHALL pulse parity_err instead of rx_dv, with rx_data unchanged; frame_err takes precedence over parity_err.
REQ-025 Without SERIAL_RX_PARITY_EN, the frame SHALL be 8N1, no PARITY state SHALL exist, and parity_err SHALL be tied to 0.

Verification
REQ-026 8N1 byte 0xA5 at 115200 baud -> rx_data=0xA5; a single rx_dv pulse about 8249 cycles (+/-3) after the start edge; frame_err=0.
REQ-027 Back-to-back bytes 0x00 then 0xFF with no idle gap -> two rx_dv pulses with rx_data 0x00 then 0xFF.
REQ-028 rx low pulse of 200 cycles then high -> no rx_dv or frame_err pulse; state returns to IDLE.
REQ-029 Byte 0x3C with the stop bit driven low -> one frame_err pulse; rx_data keeps its previous value.
REQ-030 rst_n pulsed low during bit 4 of byte 0x55, then byte 0x81 sent -> no pulse for 0x55; rx_data=0x81 with one rx_dv pulse.
REQ-031 With SERIAL_RX_PARITY_EN: byte 0x07 with parity bit 1 -> rx_dv with 0x07; the same byte with parity bit 0 -> one parity_err pulse and no rx_dv.
